// File: rtl/ps2_key_decoder_pkg.sv
// Package for the PS/2 key decoder: scan-code constants, frame FSM states,
// the key-pulse bundle and the scan-code to key mapping.
package ps2_key_decoder_pkg;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } frame_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic enter;
        logic space;
    } keys_t;

    // Map a make code to a key; ext selects the E0-prefixed table. Enter is in both.
    function automatic keys_t decode_key(input logic [7:0] code, input logic ext);
        keys_t k;
        k = '0;
        if (ext) begin
            case (code)
                SC_UP:    k.up    = 1'b1;
                SC_DOWN:  k.down  = 1'b1;
                SC_LEFT:  k.left  = 1'b1;
                SC_RIGHT: k.right = 1'b1;
                SC_ENTER: k.enter = 1'b1;
                default:  k       = '0;
            endcase
        end else begin
            case (code)
                SC_W:     k.up    = 1'b1;
                SC_S:     k.down  = 1'b1;
                SC_A:     k.left  = 1'b1;
                SC_D:     k.right = 1'b1;
                SC_ENTER: k.enter = 1'b1;
                SC_SPACE: k.space = 1'b1;
                default:  k       = '0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_clk_filter.sv
// PS/2 input conditioning: 2-FF synchronisers on clock and data, a stability
// filter on the clock and falling-edge detection of the filtered clock.
// Ports:
//   clk_i, rst_ni   system clock, async active-low reset
//   ps2_clk_i       raw PS/2 clock pin
//   ps2_data_i      raw PS/2 data pin
//   clk_filt_o      filtered PS/2 clock level
//   data_sync_o     synchronised PS/2 data
//   fe_o            1-cycle pulse on each filtered falling edge
module ps2_key_decoder_clk_filter #(
    parameter int unsigned FilterLen = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_filt_o,
    output logic data_sync_o,
    output logic fe_o
);

    localparam int unsigned CntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FilterLen - 1);

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fe_q, fe_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fe_q        <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fe_q        <= fe_d;
        end
    end

    // The filtered level flips on the FilterLen-th consecutive differing sample;
    // any sample equal to the current level restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        fe_d   = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CntMax) begin
                filt_d = clk_sync_q[1];
                fe_d   = filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign clk_filt_o  = filt_q;
    assign data_sync_o = data_sync_q[1];
    assign fe_o        = fe_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scan-code decoder producing 1-cycle key pulses.
// Ports:
//   clk_i, rst_ni                    system clock, async active-low reset
//   ps2_clk_i, ps2_data_i            raw PS/2 pins
//   up_o .. space_o                  1-cycle key pulses
//   key_valid_o                      1-cycle pulse per accepted byte
//   scan_code_o                      last accepted byte
//   frame_err_o                      1-cycle pulse on parity/stop error or timeout
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned FilterLen     = 8,
    parameter int unsigned TimeoutCycles = 200000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       up_o,
    output logic       down_o,
    output logic       left_o,
    output logic       right_o,
    output logic       enter_o,
    output logic       space_o,
    output logic       key_valid_o,
    output logic [7:0] scan_code_o,
    output logic       frame_err_o
);

    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    logic clk_filt, data_s, fe;

    ps2_key_decoder_clk_filter #(
        .FilterLen(FilterLen)
    ) u_clk_filter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .clk_filt_o (clk_filt),
        .data_sync_o(data_s),
        .fe_o       (fe)
    );

    frame_state_e    state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            brk_q, brk_d, ext_q, ext_d;
    keys_t           keys_q, keys_d;
    logic            key_valid_q, key_valid_d;
    logic [7:0]      scan_q, scan_d;
    logic            err_q, err_d;
    logic            tmo_hit, frame_ok, frame_bad;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            keys_q      <= '0;
            key_valid_q <= 1'b0;
            scan_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            keys_q      <= keys_d;
            key_valid_q <= key_valid_d;
            scan_q      <= scan_d;
            err_q       <= err_d;
        end
    end

    // An edge arriving on the timeout cycle wins: the frame is still alive.
    assign tmo_hit   = (state_q != StIdle) && !fe && (tmo_q == TmoLast);
    assign frame_ok  = fe && (state_q == StStop) && data_s && (^{shift_q, parity_q});
    assign frame_bad = (fe && (state_q == StStop) && !frame_ok) || tmo_hit;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (fe) begin
            unique case (state_q)
                StIdle:   if (!data_s) state_d = StData;
                StData:   if (cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
        if (tmo_hit) state_d = StIdle;
    end

    // Frame datapath and timeout counter
    always_comb begin
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tmo_d    = (fe || state_q == StIdle) ? '0 : tmo_q + 1'b1;
        if (fe) begin
            case (state_q)
                StIdle:   cnt_d = '0;
                StData: begin
                    shift_d = {data_s, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                end
                StParity: parity_d = data_s;
                default:  cnt_d = cnt_q;
            endcase
        end
    end

    // Outputs and prefix flags
    always_comb begin
        keys_d      = '0;
        key_valid_d = 1'b0;
        scan_d      = scan_q;
        err_d       = frame_bad;
        brk_d       = brk_q;
        ext_d       = ext_q;
        if (frame_bad) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (frame_ok) begin
            key_valid_d = 1'b1;
            scan_d      = shift_q;
            if (shift_q == SC_BRK) begin
                brk_d = 1'b1;
            end else if (shift_q == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                if (!brk_q) keys_d = decode_key(shift_q, ext_q);
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    assign up_o        = keys_q.up;
    assign down_o      = keys_q.down;
    assign left_o      = keys_q.left;
    assign right_o     = keys_q.right;
    assign enter_o     = keys_q.enter;
    assign space_o     = keys_q.space;
    assign key_valid_o = key_valid_q;
    assign scan_code_o = scan_q;
    assign frame_err_o = err_q;

    logic unused_filt;
    assign unused_filt = clk_filt;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: every driven byte pushes its expected
// output event; the monitor pops and compares whenever the DUT pulses.
module tb_ps2_key_decoder;

    localparam int unsigned FilterLen = 8;
    localparam int unsigned Tmo       = 1000;
    localparam int          Half      = 30;

    typedef struct packed {
        logic       err;
        logic       kv;
        logic [5:0] keys;
        logic [7:0] scan;
    } ev_t;

    logic       clk, rst_n, ps2_clk, ps2_data;
    logic       up, down, left, right, enter, space, key_valid, frame_err;
    logic [7:0] scan_code;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_events = 0;
    ev_t  exp_q[$];
    logic m_brk = 0, m_ext = 0;
    logic [7:0] m_scan = 8'h00;

    ps2_key_decoder #(
        .FilterLen    (FilterLen),
        .TimeoutCycles(Tmo)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .up_o       (up),
        .down_o     (down),
        .left_o     (left),
        .right_o    (right),
        .enter_o    (enter),
        .space_o    (space),
        .key_valid_o(key_valid),
        .scan_code_o(scan_code),
        .frame_err_o(frame_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference key table {up,down,left,right,enter,space}
    function automatic logic [5:0] ref_keys(input logic [7:0] code, input logic ext);
        case ({ext, code})
            {1'b0, 8'h1D}, {1'b1, 8'h75}: return 6'b100000;
            {1'b0, 8'h1B}, {1'b1, 8'h72}: return 6'b010000;
            {1'b0, 8'h1C}, {1'b1, 8'h6B}: return 6'b001000;
            {1'b0, 8'h23}, {1'b1, 8'h74}: return 6'b000100;
            {1'b0, 8'h5A}, {1'b1, 8'h5A}: return 6'b000010;
            {1'b0, 8'h29}:                return 6'b000001;
            default:                      return 6'b000000;
        endcase
    endfunction

    task automatic push_good(input logic [7:0] b);
        logic [5:0] k;
        k = 6'b0;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (!m_brk) k = ref_keys(b, m_ext);
            m_brk = 0;
            m_ext = 0;
        end
        m_scan = b;
        exp_q.push_back({1'b0, 1'b1, k, b});
    endtask

    task automatic push_err();
        m_brk = 0;
        m_ext = 0;
        exp_q.push_back({1'b1, 1'b0, 6'b0, m_scan});
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (Half) @(posedge clk);
        ps2_clk = 0;
        repeat (Half) @(posedge clk);
        ps2_clk = 1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_par || bad_stop) push_err();
        else push_good(b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1;
        repeat (2 * Half) @(posedge clk);
    endtask

    task automatic expect_drained(input string tag);
        check_eq(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (key_valid || frame_err || up || down || left || right || enter || space))
        begin
            ev_t obs;
            obs = {frame_err, key_valid, up, down, left, right, enter, space, scan_code};
            n_events++;
            if (exp_q.size() == 0) check_eq("unexpected_event", 32'(obs), 32'h0);
            else check_eq("event", 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int ev0;
        rst_n = 0;
        ps2_clk = 1;
        ps2_data = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", {up, down, left, right, enter, space, key_valid, frame_err,
                 scan_code}, 0);
        rst_n = 1;
        repeat (20) @(posedge clk);

        // W, then plain/extended make codes, unmapped and releases
        send(8'h1D, 0, 0);
        expect_drained("t1_w");
        send(8'hE0, 0, 0); send(8'h75, 0, 0);
        send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
        expect_drained("t2_ext_up");
        send(8'h1C, 0, 0); send(8'h1B, 0, 0); send(8'h23, 0, 0);
        send(8'hE0, 0, 0); send(8'h6B, 0, 0);
        send(8'h5A, 0, 0); send(8'hE0, 0, 0); send(8'h5A, 0, 0);
        send(8'h16, 0, 0);
        send(8'hE0, 0, 0); send(8'h1D, 0, 0);
        send(8'hF0, 0, 0); send(8'h1D, 0, 0);
        send(8'h29, 0, 0);
        expect_drained("t_map");

        // Parity error, stop error, then recovery; error clears pending prefix
        send(8'h29, 1, 0);
        send(8'h29, 0, 0);
        send(8'hE0, 0, 0); send(8'h74, 0, 1); send(8'h23, 0, 0);
        expect_drained("t3_parity");

        // Timeout mid-frame
        push_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data = 1;
        repeat (Tmo + 100) @(posedge clk);
        expect_drained("t4_timeout");
        send(8'h5A, 0, 0);
        expect_drained("t4_enter");

        // Short clock glitch must be ignored
        ev0 = n_events;
        @(negedge clk);
        ps2_clk = 0;
        repeat (FilterLen - 1) @(negedge clk);
        ps2_clk = 1;
        repeat (100) @(posedge clk);
        check_eq("t5_glitch_events", n_events - ev0, 0);
        send(8'h1B, 0, 0);
        expect_drained("t5_after");

        // Reset mid-frame with an extended prefix pending
        send(8'hE0, 0, 0);
        ps2_bit(1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(1'b1);
        rst_n = 0;
        m_brk = 0; m_ext = 0; m_scan = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("t6_reset_outs", {up, down, left, right, enter, space, key_valid, frame_err,
                 scan_code}, 0);
        ps2_clk = 1;
        ps2_data = 1;
        @(posedge clk);
        rst_n = 1;
        repeat (20) @(posedge clk);
        send(8'h23, 0, 0);
        @(negedge clk);
        check_eq("t6_scan", scan_code, 8'h23);
        expect_drained("t6_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
